// File: rtl/tile_background_renderer.sv
// -----------------------------------------------------------------------------
// tile_background_renderer
//
// Renders one 160x120 frame of a scrolling, tile-based background into a VGA
// adapter. Each tile is 8x8 pixels. The tile code for every pixel is read from
// a synchronous level ROM, addressed by {world_col, row}. One pixel is issued
// per cycle in raster order through a two-stage pipeline. The first stage
// covers the ROM access. The second stage resolves the colour and drives the
// plot strobe.
//
// Parameters
//   SKY_COLOR      colour used for tile_code 0
//   OUTLINE_COLOR  colour used on local x==0 / local y==0 of non-zero tiles
//
// Ports
//   CLOCK_50       sole clock, rising edge
//   resetn         asynchronous active-low reset
//   enable         frame request, level-sensitive; dropping it aborts a frame
//   x_offset       world-pixel scroll position, sampled when a frame starts
//   tile_code      level ROM read data, valid one cycle after level_address
//   level_address  level ROM address {world_col[10:0], row[3:0]}
//   x, y           screen pixel coordinate of the plotted pixel
//   color          RRRGGGBBB colour of the plotted pixel
//   plot           pixel write strobe
//   done           frame complete; held while enable stays high
// -----------------------------------------------------------------------------
module tile_background_renderer #(
    parameter logic [8:0] SKY_COLOR     = 9'o077,
    parameter logic [8:0] OUTLINE_COLOR = 9'o000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        enable,
    input  logic [31:0] x_offset,
    input  logic [3:0]  tile_code,
    output logic [14:0] level_address,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [8:0]  color,
    output logic        plot,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t      state, next_state;
    logic [13:0] off_r;
    logic [7:0]  sx;
    logic [6:0]  sy;
    logic        flush_cnt;
    logic [13:0] wx;
    logic        last_pix;

    logic        s1_valid;
    logic [7:0]  s1_x;
    logic [6:0]  s1_y;
    logic [2:0]  s1_lx;
    logic [2:0]  s1_ly;
    logic [8:0]  pix_color;

    // Only the low 14 bits of the scroll position matter: the world wraps
    // every 2048 columns of 8 pixels.
    logic unused_offset_bits;
    assign unused_offset_bits = ^x_offset[31:14];

    assign wx       = off_r + {6'd0, sx};
    assign last_pix = (sx == 8'd159) && (sy == 7'd119);

    assign level_address = (state == SCAN) ? {wx[13:3], sy[6:3]} : 15'd0;
    assign done          = (state == DONE);

    // NOTE: always_ff uses only non-blocking assignments. This way every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is given a default before any branch. This keeps the
    // block purely combinational, so no latch is inferred.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = SCAN;
                SCAN:    if (last_pix) next_state = FLUSH;
                FLUSH:   if (flush_cnt) next_state = DONE;
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Screen counters, scroll latch and flush timer. The counters only run
    // while scanning. Any other condition, including an abort, returns them
    // to the origin.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            off_r     <= '0;
            sx        <= '0;
            sy        <= '0;
            flush_cnt <= 1'b0;
        end else begin
            if (state == IDLE && enable) begin
                off_r <= x_offset[13:0];
            end
            if (state == SCAN && enable && !last_pix) begin
                if (sx == 8'd159) begin
                    sx <= '0;
                    sy <= sy + 7'd1;
                end else begin
                    sx <= sx + 8'd1;
                end
            end else begin
                sx <= '0;
                sy <= '0;
            end
            flush_cnt <= (state == FLUSH) && enable;
        end
    end

    // Stage 1 runs alongside the ROM read. The local tile coordinates ride
    // with the pixel until tile_code arrives.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_lx    <= '0;
            s1_ly    <= '0;
        end else begin
            s1_valid <= (state == SCAN) && enable;
            s1_x     <= sx;
            s1_y     <= sy;
            s1_lx    <= wx[2:0];
            s1_ly    <= sy[2:0];
        end
    end

    always_comb begin
        pix_color = SKY_COLOR;
        if (tile_code != 4'd0) begin
            if (s1_lx == 3'd0 || s1_ly == 3'd0) begin
                pix_color = OUTLINE_COLOR;
            end else begin
                pix_color = {tile_code[3:1], tile_code[3:1], tile_code[2:0]};
            end
        end
    end

    // Stage 2 drives the adapter. Dropping enable kills any in-flight pixel.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
        end else begin
            plot <= s1_valid && enable;
            if (s1_valid && enable) begin
                x     <= s1_x;
                y     <= s1_y;
                color <= pix_color;
            end
        end
    end

endmodule

// File: tb/tb_tile_background_renderer.sv
// -----------------------------------------------------------------------------
// Testbench for tile_background_renderer.
//
// A level ROM model answers level_address one cycle later. For each frame,
// every cycle is compared against a pixel-index model. Pixel k is at screen
// position (k % 160, k / 160). Its address is presented k cycles after the
// sampling edge, and it is plotted two cycles after that.
// -----------------------------------------------------------------------------
module tb_tile_background_renderer;

    localparam logic [8:0] SKY     = 9'o077;
    localparam logic [8:0] OUTLINE = 9'o000;
    localparam int         NPIX    = 160 * 120;

    logic        CLOCK_50;
    logic        resetn;
    logic        enable;
    logic [31:0] x_offset;
    logic [3:0]  tile_code;
    logic [14:0] level_address;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  color;
    logic        plot;
    logic        done;

    logic [3:0]  rom [32768];
    logic [31:0] frame_off;
    int          n_checks;
    int          n_fail;

    tile_background_renderer #(
        .SKY_COLOR     (SKY),
        .OUTLINE_COLOR (OUTLINE)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .enable        (enable),
        .x_offset      (x_offset),
        .tile_code     (tile_code),
        .level_address (level_address),
        .x             (x),
        .y             (y),
        .color         (color),
        .plot          (plot),
        .done          (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous level ROM.
    always @(posedge CLOCK_50) tile_code <= rom[level_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // World pixel column of screen pixel k in the current frame.
    function automatic int unsigned world_x(input int k);
        logic [31:0] sum;
        sum = frame_off + 32'(k % 160);
        return int'(sum % 32'd16384);
    endfunction

    function automatic int unsigned exp_addr(input int k);
        return (world_x(k) / 8) * 16 + (k / 160) / 8;
    endfunction

    function automatic int unsigned exp_color(input int k);
        int unsigned t;
        int unsigned r;
        t = rom[exp_addr(k)];
        if (t == 0) return SKY;
        if (world_x(k) % 8 == 0 || (k / 160) % 8 == 0) return OUTLINE;
        r = t / 2;
        return r * 64 + r * 8 + t % 8;
    endfunction

    // kind 0: full frame followed by a 100-cycle done hold,
    // kind 1: enable dropped after cycle abort_at,
    // kind 2: reset asserted after cycle abort_at.
    task automatic run_frame(input logic [31:0] off, input int abort_at, input int kind);
        int last_e;
        bit exp_plot;
        frame_off = off;
        x_offset  = off;
        enable    = 1'b1;
        last_e    = (kind == 0) ? NPIX + 2 + 100 : abort_at;
        for (int e = 0; e <= last_e; e++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (e == 0) x_offset = $urandom;
            check("level_address", level_address, (e < NPIX) ? exp_addr(e) : 0);
            exp_plot = (e >= 2) && (e <= NPIX + 1);
            check("plot", plot, exp_plot);
            if (exp_plot) begin
                check("x", x, (e - 2) % 160);
                check("y", y, (e - 2) / 160);
                check("color", color, exp_color(e - 2));
            end
            check("done", done, e >= NPIX + 2);
            if (frame_off == 5 && e == 2) check("off5_sx2_col0", level_address, 0);
            if (frame_off == 5 && e == 3) check("off5_sx3_col1", level_address, 16);
            if (frame_off == 5 && e == 5)
                check("off5_sx3_outline", color, (rom[16] != 0) ? OUTLINE : SKY);
            if (frame_off == 16380 && e == 3) check("wrap_sx3_col2047", level_address, 2047 * 16);
            if (frame_off == 16380 && e == 4) check("wrap_sx4_col0", level_address, 0);
        end
        if (kind == 2) begin
            resetn = 1'b0;
            enable = 1'b0;
            #1;
            check("rst_plot", plot, 0);
            check("rst_x", x, 0);
            check("rst_y", y, 0);
            check("rst_color", color, 0);
            check("rst_addr", level_address, 0);
            check("rst_done", done, 0);
            @(negedge CLOCK_50);
            resetn = 1'b1;
        end else begin
            enable = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            check("idle_plot", plot, 0);
            check("idle_done", done, 0);
            check("idle_addr", level_address, 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 32768; a++) rom[a] = 4'(a);

        // Reset held with enable already high.
        resetn   = 1'b0;
        enable   = 1'b1;
        x_offset = 32'd0;
        #22;
        check("reset_addr", level_address, 0);
        check("reset_x", x, 0);
        check("reset_y", y, 0);
        check("reset_color", color, 0);
        check("reset_plot", plot, 0);
        check("reset_done", done, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // First edge after release starts the frame. Hold enable after done.
        run_frame(32'd0, 0, 0);

        for (int a = 0; a < 32768; a++) rom[a] = 4'($urandom_range(0, 15));

        run_frame(32'd5, 300, 1);
        run_frame(32'd16380, 300, 1);
        run_frame($urandom, 1000, 2);
        run_frame($urandom, 5000, 1);
        run_frame($urandom, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_background_renderer.md
TILE_BACKGROUND_RENDERER -- requirements
Module: tile_background_renderer

Interface
REQ-001 Parameter SKY_COLOR, default 9'o077, colour SHALL be drawn for tile_code 0.
REQ-002 Parameter OUTLINE_COLOR, default 9'o000, colour SHALL be drawn on the tile outline pixels of non-zero tiles.
REQ-003 Port CLOCK_50  input  1: sole clock; all state updates on rising edge.
REQ-004 Port resetn  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: frame request from the main state machine; level-sensitive.
REQ-006 Port x_offset  input  32: world-pixel scroll position, sampled once per frame.
REQ-007 Port tile_code  input  4: level-memory read data, valid one cycle after level_address (synchronous ROM).
REQ-008 Port level_address  output  15: level-memory address = {world_col[10:0], row[3:0]}.
REQ-009 Port x  output  8: screen pixel x, 0..159.
REQ-010 Port y  output  7: screen pixel y, 0..119.
REQ-011 Port color  output  9: RRRGGGBBB pixel colour.
REQ-012 Port plot  output  1: pixel write strobe to the VGA adapter.
REQ-013 Port done  output  1: frame complete.

Function
REQ-014 The block SHALL implement states IDLE, SCAN, FLUSH, DONE.
REQ-015 IDLE with enable=1 at an edge SHALL go to SCAN, latch x_offset into off_r, and clear screen counters sx=0, sy=0.
REQ-016 SCAN order SHALL be raster: sx 0..159, then sx wraps to 0 and sy increments, through sy=119 (19200 pixels, one per cycle, no stalls).
REQ-017 In SCAN, level_address SHALL be combinational from the counters: wx = (off_r + sx) truncated to 14 bits, world_col = wx[13:3], row = sy[6:3].
REQ-018 World columns SHALL wrap modulo 2048 (wx modulo 16384) without error.
REQ-019 Pipeline stage 1 SHALL register sx, sy, wx[2:0], sy[2:0], valid alongside the ROM access.
REQ-020 Stage 2 SHALL register x, y, color, plot; a pixel whose address is presented in cycle n SHALL appear on x/y/color with plot=1 after edge n+2.
REQ-021 Colour rule: tile_code 0 -> SKY_COLOR.
REQ-022 Colour rule: non-zero tile_code with local x==0 or local y==0 -> OUTLINE_COLOR.
REQ-023 Colour rule: any other non-zero tile_code pixel -> {tile_code[3:1], tile_code[3:1], tile_code[2:0]}.
REQ-024 After the last pixel address (sx=159, sy=119), the state SHALL go to FLUSH for 2 cycles, then to DONE.
REQ-025 done SHALL rise 19202 edges after the enable-sampling edge, in the same cycle plot falls to 0.
REQ-026 In DONE, done SHALL stay 1 and plot 0 while enable=1; no re-render occurs.
REQ-027 enable=0 in any state SHALL force IDLE at the next edge, with plot=0, done=0, pipeline valid bits cleared, and counters cleared; an aborted frame is never resumed.
REQ-028 A new enable rise after abort or DONE SHALL start a full frame with a freshly sampled x_offset.
REQ-029 In IDLE, FLUSH and DONE, level_address SHALL be 0 and no new pixels SHALL enter the pipeline.
REQ-030 x_offset changes after the sampling edge SHALL NOT affect the current frame.

Reset
REQ-031 resetn=0 SHALL immediately force state IDLE and clear every output (level_address, x, y, color, plot, done) and every internal register to 0.
REQ-032 After resetn rises, the block SHALL wait in IDLE for enable.
REQ-033 Reset asserted mid-SCAN SHALL drop plot within the same cycle, with no partial pixel emitted after release.

Verification
REQ-034 Reset with enable=1 -> all outputs 0; after release, SCAN starts on the first edge.
REQ-035 x_offset=0, ROM model tile_code = address[3:0] -> first plot (0,0) at edge 2; pixel colour matches REQ-021..023; exactly 19200 plots; done at edge 19202.
REQ-036 x_offset=5 -> pixel sx=3 reads world_col 1 with local x 0 (OUTLINE_COLOR if non-zero); sx=2 reads world_col 0.
REQ-037 x_offset=16380 -> sx=3 addresses col 2047; sx=4 addresses col 0 (wrap).
REQ-038 enable dropped at pixel 5000 -> plot 0 next edge, done never rises; re-enable -> frame restarts at (0,0).
REQ-039 enable held after done -> done stays 1, plot stays 0, level_address stays 0 for 100 cycles.
